clint_vec: RTL and testbench
============================

// Module: clint_vec
// PURPOSE
//  Parametrised core-local interrupt controller: NUM_SRC maskable sources with pending capture,
//  fixed or round-robin arbitration, and a PMP-exception input. Performs the trap entry sequence
//  (mepc, mcause, mstatus save), redirects to mtvec (direct/vectored) and restores on MRET.
//  Sits between core/id/ctrl and csr_reg; drives int_assert_o/int_addr_o into ex.
// PARAMETERS
//  NUM_SRC    8        number of interrupt sources (1..16)
//  EDGE_MODE  1        1: pending set on irq rising edge; 0: pending follows level
//  RR_MODE    0        0: fixed priority, lowest index wins; 1: round robin after last granted
//  IRQ_BASE   16       mcause code of source 0 (source k -> IRQ_BASE+k, bit31=1)
//  PMP_CAUSE  32'h1    mcause written for PMP exception (bit31=0)
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, synchronous, active-high
//  irq_i         in   NUM_SRC  interrupt request lines
//  irq_en_i      in   NUM_SRC  per-source enable (mie image)
//  pmp_exc_i     in   1        PMP access fault, single-cycle pulse
//  inst_i        in   32       instruction in id
//  inst_addr_i   in   32       address of instruction in id
//  hold_i        in   1        any pipeline hold from ctrl
//  csr_rdata_i   in   32       csr_reg combinational read data for csr_raddr_o
//  csr_raddr_o   out  32       CSR read address
//  csr_we_o      out  1        CSR write enable
//  csr_waddr_o   out  32       CSR write address
//  csr_wdata_o   out  32       CSR write data
//  int_assert_o  out  1        redirect strobe to ex (one cycle)
//  int_addr_o    out  32       redirect target
//  busy_o        out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, rr pointer=0, exc latch=0; all outputs 0 except csr_raddr_o=MTVEC.
//  Pending: EDGE_MODE=1 sets bit k on irq_i[k] 0->1, cleared only when k is granted; EDGE_MODE=0
//   pending=irq_i. pmp_exc_i sets exc latch in any state; cleared when exception is taken.
//  Request = exc latch | |(pending & irq_en_i) & mstatus.MIE (csr_rdata_i[3] sampled in IDLE,
//   raddr=MSTATUS in IDLE). Exception ignores MIE and beats every irq.
//  States (one-hot, all transitions on clk):
//   IDLE: if request & !hold_i -> SAVE_EPC; latch winner code, epc=inst_addr_i, clear its pending.
//   SAVE_EPC: we=1, waddr=MEPC, wdata=epc; raddr=MSTATUS, mstatus_q<=csr_rdata_i -> SAVE_CAUSE.
//   SAVE_CAUSE: we=1, waddr=MCAUSE, wdata=cause -> SAVE_STATUS.
//   SAVE_STATUS: we=1, waddr=MSTATUS, wdata=mstatus_q with MPIE=MIE, MIE=0 -> ASSERT.
//   ASSERT: raddr=MTVEC; int_assert_o=1; int_addr_o=base if mtvec[1:0]=00 or exception,
//    else {mtvec[31:2],2'b00}+4*code -> WAIT_MRET.
//   WAIT_MRET: raddr=MSTATUS; if inst_i==INST_MRET & !hold_i: mstatus_q<=csr_rdata_i -> RESTORE.
//   RESTORE: we=1, waddr=MSTATUS, wdata=mstatus_q with MIE=MPIE, MPIE=1 -> RETURN.
//   RETURN: raddr=MEPC; int_assert_o=1, int_addr_o=csr_rdata_i -> IDLE.
//  csr_we_o/waddr/wdata and int_* are combinational decodes of state; we=0, int_*=0 elsewhere.
//  Latency: request seen in IDLE at edge N -> int_assert_o high in cycle N+4, exactly one cycle.
//  No nesting: irqs arriving after IDLE stay pending; exc latch holds until next IDLE.
//  Simultaneous: pmp_exc_i and irq same cycle -> exception first, irq taken after RETURN.
//  RR_MODE=1: search starts at last granted index+1, wraps NUM_SRC-1 -> 0; pointer updates on grant.
//  hold_i in IDLE defers entry; hold_i never stalls SAVE_*/ASSERT/RESTORE/RETURN.
//  rst in any state -> IDLE next edge, pending cleared, no CSR write that cycle.
// STRUCTURE
//  defines.v gains CSR_MSTATUS, CLINT_IRQ_BASE, CLINT_PMP_CAUSE, mstatus bit indices MIE/MPIE.
//  Sub-module clint_prio_arb: pending&enable vector + rr pointer -> grant valid + index (comb.).
//  State machine, pending/exc latches and CSR sequencing stay in clint_vec.
// TESTING
//  MIE=1, irq_en=8'hFF, irq_i[3] rises, inst_addr=0x100 -> writes MEPC=0x100, MCAUSE=0x80000013,
//   MSTATUS MIE 1->0; int_assert_o at N+4 with int_addr=mtvec base.
//  irq_i[5] and irq_i[2] rise together, RR_MODE=0 -> 2 serviced first; 5 after MRET, cause 0x80000015.
//  pmp_exc_i pulse with irq_i[0] pending, MIE=0 -> MCAUSE=0x1, irq not taken until MIE restored.
//  mtvec=0x2001, irq 4 -> int_addr_o=0x2000+4*20=0x2050; exception same mtvec -> 0x2000.
//  MRET in WAIT_MRET with hold_i=1 two cycles -> no RESTORE until hold_i=0; then RETURN int_addr=mepc.
//  rst mid SAVE_CAUSE -> IDLE next cycle, csr_we_o=0, pending=0, busy_o=0.

Source files
------------

// File: rtl/clint_vec_pkg.sv
// Shared CSR addresses, mstatus bit positions, FSM encodings and mstatus
// rewrite helpers for the core-local interrupt controller.
package clint_vec_pkg;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int          CLINT_IRQ_BASE  = 16;
    localparam logic [31:0] CLINT_PMP_CAUSE = 32'h0000_0001;

    // One-hot trap sequencer states
    localparam logic [7:0] ST_IDLE        = 8'b0000_0001;
    localparam logic [7:0] ST_SAVE_EPC    = 8'b0000_0010;
    localparam logic [7:0] ST_SAVE_CAUSE  = 8'b0000_0100;
    localparam logic [7:0] ST_SAVE_STATUS = 8'b0000_1000;
    localparam logic [7:0] ST_ASSERT      = 8'b0001_0000;
    localparam logic [7:0] ST_WAIT_MRET   = 8'b0010_0000;
    localparam logic [7:0] ST_RESTORE     = 8'b0100_0000;
    localparam logic [7:0] ST_RETURN      = 8'b1000_0000;

    function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_vec_if.sv
// Bundle between the interrupt controller, the id/ctrl stage, csr_reg and ex.
interface clint_vec_if #(
    parameter int NUM_SRC = 8
) ();
    logic [NUM_SRC-1:0] irq_i;
    logic [NUM_SRC-1:0] irq_en_i;
    logic               pmp_exc_i;
    logic [31:0]        inst_i;
    logic [31:0]        inst_addr_i;
    logic               hold_i;
    logic [31:0]        csr_rdata_i;
    logic [31:0]        csr_raddr_o;
    logic               csr_we_o;
    logic [31:0]        csr_waddr_o;
    logic [31:0]        csr_wdata_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;
    logic               busy_o;

    modport slave (
        input  irq_i, irq_en_i, pmp_exc_i, inst_i, inst_addr_i, hold_i, csr_rdata_i,
        output csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, busy_o
    );

    modport master (
        output irq_i, irq_en_i, pmp_exc_i, inst_i, inst_addr_i, hold_i, csr_rdata_i,
        input  csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, busy_o
    );
endinterface

// File: rtl/clint_prio_arb.sv
// Combinational arbiter: lowest index wins, or (RR_MODE=1) the search starts one
// past the last granted index and wraps.
module clint_prio_arb #(
    parameter int NUM_SRC = 8,
    parameter int RR_MODE = 0,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    int base;
    int pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        base  = (RR_MODE != 0) ? int'(last) + 1 : 0;
        pos   = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            pos = base + off;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            if (!valid && req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller: pending capture, PMP exception latch, and the
// CSR save / redirect / MRET restore sequence.
module clint_vec
    import clint_vec_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter int          EDGE_MODE = 1,
    parameter int          RR_MODE   = 0,
    parameter int          IRQ_BASE  = CLINT_IRQ_BASE,
    parameter logic [31:0] PMP_CAUSE = CLINT_PMP_CAUSE
) (
    input logic        clk,
    input logic        rst,
    clint_vec_if.slave bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [7:0]         state_reg, state_next;
    logic [NUM_SRC-1:0] pending_reg, pending_next, irq_prev_reg;
    logic [NUM_SRC-1:0] pend_vec, req_vec, grant_mask;
    logic               exc_reg, is_exc_reg;
    logic [IDX_W-1:0]   rr_ptr_reg, arb_idx;
    logic               arb_valid;
    logic [31:0]        epc_reg, cause_reg, mstatus_reg, tvec_base;
    logic               is_idle, take, take_exc, take_irq, mret_go;

    assign is_idle = (state_reg == ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            if (EDGE_MODE != 0) begin : g_edge
                assign pend_vec[gi]     = pending_reg[gi];
                assign pending_next[gi] = (pending_reg[gi] & ~grant_mask[gi])
                                        | (bus.irq_i[gi] & ~irq_prev_reg[gi]);
            end else begin : g_level
                assign pend_vec[gi]     = bus.irq_i[gi];
                assign pending_next[gi] = bus.irq_i[gi];
            end
            assign grant_mask[gi] = take_irq && (arb_idx == IDX_W'(gi));
        end
    endgenerate

    assign req_vec = pend_vec & bus.irq_en_i;

    clint_prio_arb #(
        .NUM_SRC(NUM_SRC),
        .RR_MODE(RR_MODE),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req  (req_vec),
        .last (rr_ptr_reg),
        .valid(arb_valid),
        .idx  (arb_idx)
    );

    // In IDLE the read port points at mstatus, so rdata carries the live MIE bit.
    assign take     = is_idle && !bus.hold_i
                   && (exc_reg || (arb_valid && bus.csr_rdata_i[MSTATUS_MIE]));
    assign take_exc = take && exc_reg;
    assign take_irq = take && !exc_reg;
    assign mret_go  = (state_reg == ST_WAIT_MRET) && (bus.inst_i == INST_MRET) && !bus.hold_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:        if (take) state_next = ST_SAVE_EPC;
            ST_SAVE_EPC:    state_next = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE:  state_next = ST_SAVE_STATUS;
            ST_SAVE_STATUS: state_next = ST_ASSERT;
            ST_ASSERT:      state_next = ST_WAIT_MRET;
            ST_WAIT_MRET:   if (mret_go) state_next = ST_RESTORE;
            ST_RESTORE:     state_next = ST_RETURN;
            ST_RETURN:      state_next = ST_IDLE;
            default:        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            irq_prev_reg <= '0;
            exc_reg      <= 1'b0;
            rr_ptr_reg   <= '0;
            epc_reg      <= '0;
            cause_reg    <= '0;
            is_exc_reg   <= 1'b0;
            mstatus_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            irq_prev_reg <= bus.irq_i;
            exc_reg      <= (exc_reg & ~take_exc) | bus.pmp_exc_i;
            if (take) begin
                epc_reg    <= bus.inst_addr_i;
                is_exc_reg <= take_exc;
                cause_reg  <= take_exc ? PMP_CAUSE : {1'b1, 31'(IRQ_BASE) + 31'(arb_idx)};
            end
            if (take_irq) begin
                rr_ptr_reg <= arb_idx;
            end
            if ((state_reg == ST_SAVE_EPC) || mret_go) begin
                mstatus_reg <= bus.csr_rdata_i;
            end
        end
    end

    assign tvec_base = {bus.csr_rdata_i[31:2], 2'b00};

    // Outputs are pure decodes of state; reset masks them so no write can leak out.
    always_comb begin
        bus.csr_raddr_o  = CSR_MSTATUS;
        bus.csr_we_o     = 1'b0;
        bus.csr_waddr_o  = '0;
        bus.csr_wdata_o  = '0;
        bus.int_assert_o = 1'b0;
        bus.int_addr_o   = '0;
        bus.busy_o       = !is_idle;
        if (rst) begin
            bus.csr_raddr_o = CSR_MTVEC;
            bus.busy_o      = 1'b0;
        end else begin
            case (state_reg)
                ST_SAVE_EPC: begin
                    bus.csr_we_o    = 1'b1;
                    bus.csr_waddr_o = CSR_MEPC;
                    bus.csr_wdata_o = epc_reg;
                end
                ST_SAVE_CAUSE: begin
                    bus.csr_we_o    = 1'b1;
                    bus.csr_waddr_o = CSR_MCAUSE;
                    bus.csr_wdata_o = cause_reg;
                end
                ST_SAVE_STATUS: begin
                    bus.csr_we_o    = 1'b1;
                    bus.csr_waddr_o = CSR_MSTATUS;
                    bus.csr_wdata_o = mstatus_trap(mstatus_reg);
                end
                ST_ASSERT: begin
                    bus.csr_raddr_o  = CSR_MTVEC;
                    bus.int_assert_o = 1'b1;
                    if (is_exc_reg || (bus.csr_rdata_i[1:0] == 2'b00)) begin
                        bus.int_addr_o = tvec_base;
                    end else begin
                        bus.int_addr_o = tvec_base + {cause_reg[29:0], 2'b00};
                    end
                end
                ST_RESTORE: begin
                    bus.csr_we_o    = 1'b1;
                    bus.csr_waddr_o = CSR_MSTATUS;
                    bus.csr_wdata_o = mstatus_mret(mstatus_reg);
                end
                ST_RETURN: begin
                    bus.csr_raddr_o  = CSR_MEPC;
                    bus.int_assert_o = 1'b1;
                    bus.int_addr_o   = bus.csr_rdata_i;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_vec.sv
// Randomised scoreboard bench for clint_vec: a small CSR file, an MRET-issuing
// core model and a trap-sequence reference model built from the architectural rules.
module tb_clint_vec;
    import clint_vec_pkg::*;

    localparam int          NS   = 8;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        bit          redirect;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
        bit          after_mret;
    } ev_t;

    typedef struct {
        logic [7:0]  rises;
        logic [7:0]  en;
        logic [31:0] status;
        logic [31:0] tvec;
        logic [31:0] addr;
        bit          pmp;
    } trial_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clint_vec_if #(.NUM_SRC(NS)) bus ();

    clint_vec #(
        .NUM_SRC  (NS),
        .EDGE_MODE(1),
        .RR_MODE  (0),
        .IRQ_BASE (16),
        .PMP_CAUSE(32'h1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ev_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ev_cyc = 0;
    int          mret_go_cyc = 0;
    int          handler_cnt = 0;
    bit          mon_en = 1'b0;
    bit          in_handler = 1'b0;
    logic        stim_hold = 1'b0;
    logic        core_hold = 1'b0;
    logic        tb_wr = 1'b0;
    logic [31:0] tb_status_val = '0;
    logic [31:0] tb_tvec_val = '0;
    logic [31:0] m_status = '0, m_epc = '0, m_cause = '0, m_tvec = '0;

    // Reference-model state that persists across trials
    logic [NS-1:0] ref_pend = '0;
    bit            ref_exc = 1'b0;

    assign bus.hold_i = stim_hold | core_hold;

    always_comb begin
        case (bus.csr_raddr_o)
            CSR_MSTATUS: bus.csr_rdata_i = m_status;
            CSR_MEPC:    bus.csr_rdata_i = m_epc;
            CSR_MCAUSE:  bus.csr_rdata_i = m_cause;
            CSR_MTVEC:   bus.csr_rdata_i = m_tvec;
            default:     bus.csr_rdata_i = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.csr_we_o) begin
            case (bus.csr_waddr_o)
                CSR_MSTATUS: m_status <= bus.csr_wdata_o;
                CSR_MEPC:    m_epc    <= bus.csr_wdata_o;
                CSR_MCAUSE:  m_cause  <= bus.csr_wdata_o;
                CSR_MTVEC:   m_tvec   <= bus.csr_wdata_o;
                default: ;
            endcase
        end else if (tb_wr) begin
            m_status <= tb_status_val;
            m_tvec   <= tb_tvec_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Monitor: every CSR write or redirect pops one expected event
    ev_t mon_e;
    bit  mon_ok;
    always @(negedge clk) begin
        if (mon_en && (bus.csr_we_o || bus.int_assert_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event we=%0b waddr=%h wdata=%h int=%0b addr=%h",
                         bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o);
            end else begin
                mon_e = sb.pop_front();
                if (bus.int_assert_o)
                    mon_ok = mon_e.redirect && !bus.csr_we_o && (bus.int_addr_o == mon_e.addr);
                else
                    mon_ok = !mon_e.redirect && (bus.csr_waddr_o == mon_e.addr) && (bus.csr_wdata_o == mon_e.data);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL event got we=%0b waddr=%h wdata=%h int=%0b addr=%h want redirect=%0b addr=%h data=%h",
                             bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o,
                             mon_e.redirect, mon_e.addr, mon_e.data);
                end
                if (mon_e.gap > 0) begin
                    checks++;
                    if (cyc - last_ev_cyc != mon_e.gap) begin
                        errors++;
                        $display("FAIL event_spacing got=%0d want=%0d", cyc - last_ev_cyc, mon_e.gap);
                    end
                end
                if (mon_e.after_mret) begin
                    checks++;
                    if (cyc != mret_go_cyc + 1) begin
                        errors++;
                        $display("FAIL restore_timing got=%0d want=%0d", cyc, mret_go_cyc + 1);
                    end
                end
            end
            last_ev_cyc = cyc;
        end
    end

    // Core model: after an entry redirect, issue MRET (sometimes under hold)
    initial begin
        bit got;
        int d, h;
        bus.inst_i = NOP;
        forever begin
            @(negedge clk);
            if (mon_en && bus.int_assert_o) begin
                in_handler = 1'b1;
                d = $urandom_range(1, 3);
                h = (handler_cnt == 0) ? 2 : $urandom_range(0, 2);
                handler_cnt++;
                repeat (d) @(negedge clk);
                bus.inst_i = INST_MRET;
                core_hold  = 1'b1;
                repeat (h) @(negedge clk);
                core_hold   = 1'b0;
                mret_go_cyc = cyc;
                got = 1'b0;
                for (int i = 0; i < 20 && !got; i++) begin
                    @(negedge clk);
                    if (bus.int_assert_o) got = 1'b1;
                end
                checks++;
                if (!got) begin
                    errors++;
                    $display("FAIL return_redirect_timeout got=0 want=1");
                end
                bus.inst_i = NOP;
                in_handler = 1'b0;
            end
        end
    end

    // Expected event sequence for one complete trap/return, from the mstatus rules
    task automatic push_service(input bit is_exc, input int code, inout logic [31:0] s,
                                input logic [31:0] tvec, input logic [31:0] epc);
        logic [31:0] cause, saved, restored, entry, base;
        cause    = is_exc ? 32'h1 : (32'h8000_0000 | 32'(code));
        saved    = s;
        saved[7] = s[3];
        saved[3] = 1'b0;
        base     = tvec & 32'hFFFF_FFFC;
        entry    = (is_exc || tvec[1:0] == 2'b00) ? base : base + 32'(4 * code);
        restored = saved;
        restored[3] = saved[7];
        restored[7] = 1'b1;
        sb.push_back('{0, CSR_MEPC,    epc,      0, 0});
        sb.push_back('{0, CSR_MCAUSE,  cause,    1, 0});
        sb.push_back('{0, CSR_MSTATUS, saved,    1, 0});
        sb.push_back('{1, entry,       32'h0,    1, 0});
        sb.push_back('{0, CSR_MSTATUS, restored, 0, 1});
        sb.push_back('{1, epc,         32'h0,    1, 0});
        s = restored;
    endtask

    task automatic wait_idle(input int tn);
        bit done = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy_o && !in_handler) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout trial=%0d got_pending_events=%0d want=0", tn, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_trial(input int tn, input trial_t t);
        logic [31:0]   s;
        logic [NS-1:0] cand;
        int            k, nsvc;
        bit            more;
        @(negedge clk);
        stim_hold         = 1'b1;
        bus.irq_en_i      = t.en;
        bus.irq_i         = t.rises;
        bus.pmp_exc_i     = t.pmp;
        bus.inst_addr_i   = t.addr;
        tb_status_val     = t.status;
        tb_tvec_val       = t.tvec;
        tb_wr             = 1'b1;
        // Reference: exception first, then enabled pending irqs lowest-first while MIE=1
        ref_pend = ref_pend | t.rises;
        ref_exc  = ref_exc | t.pmp;
        s        = t.status;
        nsvc     = 0;
        more     = 1'b1;
        while (more) begin
            cand = ref_pend & t.en;
            if (ref_exc) begin
                ref_exc = 1'b0;
                push_service(1'b1, 0, s, t.tvec, t.addr);
                nsvc++;
            end else if (s[3] && cand != '0) begin
                k = 0;
                for (int j = NS - 1; j >= 0; j--) if (cand[j]) k = j;
                ref_pend[k] = 1'b0;
                push_service(1'b0, 16 + k, s, t.tvec, t.addr);
                nsvc++;
            end else begin
                more = 1'b0;
            end
        end
        $display("trial %0d rises=%h en=%h mstatus=%h mtvec=%h pmp=%0b services=%0d",
                 tn, t.rises, t.en, t.status, t.tvec, t.pmp, nsvc);
        @(negedge clk);
        bus.irq_i     = '0;
        bus.pmp_exc_i = 1'b0;
        tb_wr         = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        stim_hold = 1'b0;
        wait_idle(tn);
    endtask

    trial_t dir[6];
    trial_t tr;

    initial begin
        bit found, seen;
        bus.irq_i       = '0;
        bus.irq_en_i    = '0;
        bus.pmp_exc_i   = 1'b0;
        bus.inst_addr_i = '0;

        dir[0] = '{8'h08, 8'hFF, 32'h0000_0008, 32'h0000_1000, 32'h0000_0100, 1'b0};
        dir[1] = '{8'h24, 8'hFF, 32'h0000_0008, 32'h0000_1000, 32'h0000_0200, 1'b0};
        dir[2] = '{8'h01, 8'hFF, 32'h0000_0000, 32'h0000_1000, 32'h0000_0300, 1'b1};
        dir[3] = '{8'h00, 8'hFF, 32'h0000_0008, 32'h0000_1000, 32'h0000_0400, 1'b0};
        dir[4] = '{8'h10, 8'hFF, 32'h0000_0008, 32'h0000_2001, 32'h0000_0500, 1'b0};
        dir[5] = '{8'h00, 8'hFF, 32'h0000_0008, 32'h0000_2001, 32'h0000_0600, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_we",      32'(bus.csr_we_o), 32'h0);
        chk("reset_int",     32'(bus.int_assert_o), 32'h0);
        chk("reset_int_addr", bus.int_addr_o, 32'h0);
        chk("reset_busy",    32'(bus.busy_o), 32'h0);
        chk("reset_raddr",   bus.csr_raddr_o, CSR_MTVEC);
        chk("reset_waddr",   bus.csr_waddr_o, 32'h0);
        chk("reset_wdata",   bus.csr_wdata_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_raddr", bus.csr_raddr_o, CSR_MSTATUS);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) run_trial(i, dir[i]);

        for (int i = 6; i < 46; i++) begin
            tr.rises  = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            tr.en     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            tr.status = $urandom;
            tr.status[3] = ($urandom_range(0, 3) != 0);
            tr.tvec   = $urandom;
            tr.tvec[1:0] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
            tr.addr   = $urandom & 32'hFFFF_FFFC;
            tr.pmp    = ($urandom_range(0, 4) == 0);
            run_trial(i, tr);
        end

        // Reset in the middle of the save sequence, with another irq already pending
        mon_en = 1'b0;
        @(negedge clk);
        stim_hold     = 1'b1;
        bus.irq_en_i  = 8'hFF;
        bus.irq_i     = 8'h08;
        tb_status_val = 32'h0000_0008;
        tb_tvec_val   = 32'h0000_1000;
        tb_wr         = 1'b1;
        @(negedge clk);
        bus.irq_i = '0;
        tb_wr     = 1'b0;
        stim_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.csr_we_o && bus.csr_waddr_o == CSR_MEPC) found = 1'b1;
        end
        chk("rst_seq_mepc_seen", 32'(found), 32'h1);
        bus.irq_i = 8'h40;
        @(negedge clk);
        bus.irq_i = '0;
        chk("rst_seq_cause_we", 32'(bus.csr_we_o), 32'h1);
        chk("rst_seq_cause_waddr", bus.csr_waddr_o, CSR_MCAUSE);
        rst = 1'b1;
        #1;
        chk("rst_we_gated", 32'(bus.csr_we_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_after_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_after_we", 32'(bus.csr_we_o), 32'h0);
        chk("rst_after_raddr", bus.csr_raddr_o, CSR_MSTATUS);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.csr_we_o || bus.int_assert_o || bus.busy_o) seen = 1'b1;
        end
        chk("rst_pending_cleared", 32'(seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
